lut_cfg_ctrl: RTL and testbench



---
 rtl/lut_cfg_pkg.sv | 43 ++++
 rtl/lut_cfg_ctrl_if.sv | 40 ++++
 rtl/lut_cfg_ctrl.sv | 172 +++++++++++++++++
 tb/tb_lut_cfg_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_cfg_pkg.sv
// Shared types, sizing helpers and the checksum fold for the LUT
// configuration sequencer.
// Optional feature macro: LUT_CFG_CHECKSUM_EN (configuration checksum output).
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lut_cfg_state_e;

  // Default build sizes; the top module derives its own widths from its
  // parameters through the helpers below.
  localparam int DEF_LUT_SIZE = 6;
  localparam int DEF_NUM_LUTS = 8;

  function automatic int lut_word_width(input int k);
    return 1 << k;
  endfunction

  function automatic int lut_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LUT_WORD_W = lut_word_width(DEF_LUT_SIZE);
  localparam int LUT_IDX_W  = lut_idx_width(DEF_NUM_LUTS);

  localparam int CKSUM_W      = 16;
  // Widest truth table the fold accepts (K up to 8); callers zero-pad.
  localparam int FOLD_MAX_W   = 256;

  // XOR of all 16-bit slices of a zero-padded truth-table word.
  function automatic logic [CKSUM_W-1:0] xor_fold16(input logic [FOLD_MAX_W-1:0] w);
    logic [CKSUM_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < FOLD_MAX_W / CKSUM_W; i++) begin
      acc = acc ^ w[i*CKSUM_W +: CKSUM_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/lut_cfg_ctrl_if.sv
// Configuration stream and LUTRAM write-bus bundle for lut_cfg_ctrl.
// Optional feature macro: LUT_CFG_CHECKSUM_EN (adds cfg_checksum).
interface lut_cfg_ctrl_if #(
  parameter int ZUMA_LUT_SIZE = 6,
  parameter int NUM_LUTS      = 8
);
  logic                            start;
  logic                            abort;
  logic                            cfg_valid;
  logic                            cfg_ready;
  logic [(1<<ZUMA_LUT_SIZE)-1:0]   cfg_data;
  logic [ZUMA_LUT_SIZE-1:0]        lut_a;
  logic                            lut_d;
  logic [NUM_LUTS-1:0]             lut_we;
  logic                            busy;
  logic                            cfg_mode;
  logic                            done;
`ifdef LUT_CFG_CHECKSUM_EN
  logic [15:0]                     cfg_checksum;
`endif

  // Loader / bench side
  modport master (
    output start, abort, cfg_valid, cfg_data,
    input  cfg_ready, lut_a, lut_d, lut_we, busy, cfg_mode, done
`ifdef LUT_CFG_CHECKSUM_EN
    , input cfg_checksum
`endif
  );

  // Sequencer side
  modport slave (
    input  start, abort, cfg_valid, cfg_data,
    output cfg_ready, lut_a, lut_d, lut_we, busy, cfg_mode, done
`ifdef LUT_CFG_CHECKSUM_EN
    , output cfg_checksum
`endif
  );

endinterface

// File: rtl/lut_cfg_ctrl.sv
// Configuration sequencer for a cluster of LUTRAM LUTs: accepts one
// truth-table word per LUT and serialises it into 2^K single-bit writes
// with a one-hot write enable, LUT 0 first.
// Optional feature macro: LUT_CFG_CHECKSUM_EN (16-bit checksum of accepted words).
module lut_cfg_ctrl
  import lut_cfg_pkg::*;
#(
  parameter int ZUMA_LUT_SIZE = DEF_LUT_SIZE,
  parameter int NUM_LUTS      = DEF_NUM_LUTS
) (
  input  logic           clk,
  input  logic           rst_n,
  lut_cfg_ctrl_if.slave  bus
);

  localparam int K  = ZUMA_LUT_SIZE;
  localparam int W  = lut_word_width(ZUMA_LUT_SIZE);
  localparam int IW = lut_idx_width(NUM_LUTS);

  localparam logic [K:0]    CNT_LAST = (K+1)'(W - 1);
  localparam logic [K:0]    CNT_ONE  = (K+1)'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_LUTS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  lut_cfg_state_e r_state, w_state_nxt;

  logic [IW-1:0]       r_idx,  w_idx_nxt;
  logic [K:0]          r_cnt,  w_cnt_nxt;
  logic [W-1:0]        r_word, w_word_nxt;
  logic [K-1:0]        r_a,    w_a_nxt;
  logic                r_d,    w_d_nxt;
  logic [NUM_LUTS-1:0] r_we,   w_we_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                w_accept;

  assign w_accept = (r_state == LOAD) && bus.cfg_valid && !bus.abort;

`ifdef LUT_CFG_CHECKSUM_EN
  logic [CKSUM_W-1:0]    r_cksum, w_cksum_nxt;
  logic [FOLD_MAX_W-1:0] w_fold_in;

  // Zero-pad the incoming word to the fold width
  always_comb begin
    w_fold_in          = '0;
    w_fold_in[W-1:0]   = bus.cfg_data;
  end

  // Clear on start, accumulate each accepted word
  always_comb begin
    w_cksum_nxt = r_cksum;
    if (r_state == IDLE && bus.start) begin
      w_cksum_nxt = '0;
    end else if (w_accept) begin
      w_cksum_nxt = r_cksum + xor_fold16(w_fold_in);
    end
  end

  // Checksum register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cksum <= '0;
    else        r_cksum <= w_cksum_nxt;
  end

  assign bus.cfg_checksum = r_cksum;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and next values of all registered outputs/counters
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_a_nxt     = r_a;
    w_d_nxt     = r_d;
    w_we_nxt    = '0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = LOAD;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end

      LOAD: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end else if (bus.cfg_valid) begin
          w_word_nxt  = bus.cfg_data;
          w_cnt_nxt   = '0;
          w_state_nxt = WRITE;
        end
      end

      WRITE: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          // Word is shifted right so bit bit_cnt is always at position 0
          w_we_nxt   = NUM_LUTS'(1) << r_idx;
          w_a_nxt    = r_cnt[K-1:0];
          w_d_nxt    = r_word[0];
          w_word_nxt = r_word >> 1;
          w_cnt_nxt  = r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            if (r_idx == IDX_LAST) begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_idx_nxt   = r_idx + IDX_ONE;
              w_state_nxt = LOAD;
            end
          end
        end
      end

      DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_word <= '0;
      r_a    <= '0;
      r_d    <= 1'b0;
      r_we   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_cnt  <= w_cnt_nxt;
      r_word <= w_word_nxt;
      r_a    <= w_a_nxt;
      r_d    <= w_d_nxt;
      r_we   <= w_we_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign bus.cfg_ready = (r_state == LOAD);
  assign bus.lut_a     = r_a;
  assign bus.lut_d     = r_d;
  assign bus.lut_we    = r_we;
  assign bus.busy      = r_busy;
  assign bus.cfg_mode  = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_lut_cfg_ctrl.sv
// Self-checking bench for lut_cfg_ctrl (K=6, two LUTs). Expected write
// sequences, LUT contents and the checksum (LUT_CFG_CHECKSUM_EN) come from
// the bench's own reference model.
module tb_lut_cfg_ctrl;
  localparam int K = 6;
  localparam int N = 2;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lut_cfg_ctrl_if #(.ZUMA_LUT_SIZE(K), .NUM_LUTS(N)) bus ();

  lut_cfg_ctrl #(.ZUMA_LUT_SIZE(K), .NUM_LUTS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference LUTRAM array, written from the observed bus
  logic        mem [N][W];
  int unsigned done_seen = 0;
  int unsigned done_exp  = 0;
  logic [63:0] words [N];

  always @(negedge clk) begin
    if (rst_n) begin
      for (int n = 0; n < N; n++) begin
        if (bus.lut_we == (N'(1) << n)) mem[n][bus.lut_a] = bus.lut_d;
      end
      if (bus.done) done_seen++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Checksum reference: sum of 16-bit XOR folds of the pass's words
  function automatic logic [15:0] model_cksum();
    logic [15:0] s;
    s = 16'h0;
    for (int n = 0; n < N; n++)
      s = s + (words[n][15:0] ^ words[n][31:16] ^ words[n][47:32] ^ words[n][63:48]);
    return s;
  endfunction

  task automatic start_pass(input bit with_abort);
    for (int n = 0; n < N; n++)
      for (int i = 0; i < W; i++) mem[n][i] = 1'b0;
    bus.start = 1'b1;
    bus.abort = with_abort;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_mode", bus.cfg_mode, 1);
    chk("start_ready", bus.cfg_ready, 1);
    chk("start_done", bus.done, 0);
  endtask

  // Feed LUT n; optional stall, abort at write index, start pulse at write index
  task automatic load_lut(input int n, input int stall, input int abort_at,
                          input int start_at, output bit aborted);
    logic [63:0] wd;
    wd = words[n];
    aborted = 1'b0;
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_ready", bus.cfg_ready, 1);
      chk("stall_we", bus.lut_we, 0);
    end
    chk("load_ready", bus.cfg_ready, 1);
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = wd;
    step();
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = {$urandom(), $urandom()};
    chk("hs_we", bus.lut_we, 0);
    chk("hs_ready", bus.cfg_ready, 0);
    for (int i = 0; i < W; i++) begin
      step();
      chk($sformatf("we_%0d_%0d", n, i), bus.lut_we, N'(1) << n);
      chk($sformatf("a_%0d_%0d", n, i), bus.lut_a, i);
      chk($sformatf("d_%0d_%0d", n, i), bus.lut_d, wd[i]);
      bus.start = (i == start_at);
      if (i == abort_at) begin
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_we", bus.lut_we, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_ready", bus.cfg_ready, 0);
        aborted = 1'b1;
        return;
      end
    end
    bus.start = 1'b0;
    chk("end_done", bus.done, (n == N-1));
    chk("end_ready", bus.cfg_ready, (n != N-1));
`ifdef LUT_CFG_CHECKSUM_EN
    if (n == N-1) chk("cksum", bus.cfg_checksum, model_cksum());
`endif
  endtask

  task automatic finish_checks();
    logic [63:0] rb;
    step();
    chk("post_done", bus.done, 0);
    chk("post_busy", bus.busy, 0);
    chk("post_mode", bus.cfg_mode, 0);
    chk("post_we", bus.lut_we, 0);
    chk("post_ready", bus.cfg_ready, 0);
    done_exp++;
    chk("done_count", done_seen, done_exp);
    for (int n = 0; n < N; n++) begin
      for (int i = 0; i < W; i++) rb[i] = mem[n][i];
      chk($sformatf("readback_%0d", n), rb, words[n]);
    end
  endtask

  task automatic full_pass(input int stall1, input int start_at, input bit with_abort);
    bit ab;
    start_pass(with_abort);
    load_lut(0, 0, -1, start_at, ab);
    load_lut(1, stall1, -1, -1, ab);
    finish_checks();
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ready"}, bus.cfg_ready, 0);
    chk({tag, "_a"}, bus.lut_a, 0);
    chk({tag, "_d"}, bus.lut_d, 0);
    chk({tag, "_we"}, bus.lut_we, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_mode"}, bus.cfg_mode, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    bit ab;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;

    // Reset state
    step();
    check_idle_zero("reset");
`ifdef LUT_CFG_CHECKSUM_EN
    chk("reset_cksum", bus.cfg_checksum, 0);
`endif
    rst_n = 1'b1;
    step();
    step();
    check_idle_zero("idle");

    // Abort alone in IDLE has no effect
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    step();
    check_idle_zero("idle_abort");

    // Directed pass with the reference words, no stall
    words[0] = 64'hDEADBEEF_0123_4567;
    words[1] = 64'hFFFF_0000_FFFF_0000;
    full_pass(0, -1, 1'b0);

    // LOAD stall of 10 cycles before LUT 1
    words[0] = {$urandom(), $urandom()};
    words[1] = {$urandom(), $urandom()};
    full_pass(10, -1, 1'b0);

    // Abort at the 20th write of LUT 0, then a fresh pass from LUT 0
    words[0] = {$urandom(), $urandom()};
    start_pass(1'b0);
    load_lut(0, 0, 19, -1, ab);
    chk("abort_taken", ab, 1);
    repeat (4) step();
    chk("abort_no_done", done_seen, done_exp);
    chk("abort_idle_busy", bus.busy, 0);
    words[0] = {$urandom(), $urandom()};
    words[1] = {$urandom(), $urandom()};
    full_pass(2, -1, 1'b0);

    // Start pulse during WRITE is ignored
    words[0] = {$urandom(), $urandom()};
    words[1] = {$urandom(), $urandom()};
    full_pass(0, 30, 1'b0);

    // Start and abort together in IDLE: start wins
    words[0] = {$urandom(), $urandom()};
    words[1] = {$urandom(), $urandom()};
    full_pass(1, -1, 1'b1);

    // Asynchronous reset mid-WRITE
    start_pass(1'b0);
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = {$urandom(), $urandom()};
    step();
    bus.cfg_valid = 1'b0;
    repeat (5) step();
    chk("pre_rst_we", bus.lut_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_zero("async_rst");
    step();
    check_idle_zero("rst_hold");
    rst_n = 1'b1;
    step();
    check_idle_zero("rst_release");

    // Randomized passes
    for (int r = 0; r < 4; r++) begin
      words[0] = {$urandom(), $urandom()};
      words[1] = {$urandom(), $urandom()};
      full_pass($urandom_range(0, 6), ($urandom_range(0, 1) != 0) ? $urandom_range(0, 62) : -1, 1'b0);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
